// File: rtl/neuron_pkg.sv
// ---------------------------------------------------------------------------
// neuron_pkg
// Shared definitions for the neuron sequencing blocks: RAM geometry, the
// saturation ceiling for 8-bit activations and the MAC sequencer state enum.
// Optional feature macro: NEURON_BIAS_EN adds the BIAS state.
// ---------------------------------------------------------------------------
package neuron_pkg;

    localparam int RAM_AW = 8;
    localparam int RAM_DW = 8;

    // Largest value an activation can take after saturation.
    localparam logic [RAM_DW-1:0] SAT_MAX = 8'd255;

    typedef enum logic [2:0] {
        IDLE,
`ifdef NEURON_BIAS_EN
        BIAS,
`endif
        RD_X,
        RD_W,
        WRITE,
        DONE
    } state_t;

endpackage

// File: rtl/neuron_act_sat.sv
// ---------------------------------------------------------------------------
// neuron_act_sat
// Purely combinational activation stage: right-shifts an accumulator by a
// fixed amount and clamps the result to the 8-bit activation range.
// Ports:
//   acc  in  ACC_W  raw accumulator value
//   act  out 8      sat(acc >> SHIFT), at most SAT_MAX
// ---------------------------------------------------------------------------
module neuron_act_sat
    import neuron_pkg::*;
#(
    parameter int ACC_W = 22,
    parameter int SHIFT = 0
) (
    input  logic [ACC_W-1:0]  acc,
    output logic [RAM_DW-1:0] act
);

    logic [ACC_W-1:0] shifted;

    // Shift first, then clamp anything that no longer fits in 8 bits.
    always_comb begin
        shifted = acc >> SHIFT;
        if (shifted > {{(ACC_W-RAM_DW){1'b0}}, SAT_MAX}) begin
            act = SAT_MAX;
        end else begin
            act = shifted[RAM_DW-1:0];
        end
    end

endmodule

// File: rtl/neuron_mac_sequencer.sv
// ---------------------------------------------------------------------------
// neuron_mac_sequencer
// Evaluates one neuron over an external single-read/single-write RAM:
// reads N activation/weight pairs, accumulates their products, writes the
// shifted and saturated 8-bit result back and pulses done.
// Optional feature macro: NEURON_BIAS_EN preloads the accumulator from
// mem[bias_addr] and adds the bias_addr port.
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   start                          begin an evaluation (honoured in IDLE only)
//   n_inputs, x_base, w_base,      configuration, latched when start is taken
//   out_addr, [bias_addr]
//   busy, done, result             status and last written result
//   ram_read_address, ram_oe,      RAM read port (read data is combinational)
//   ram_read_data
//   ram_write_address,             RAM write port
//   ram_write_data, ram_wre
// ---------------------------------------------------------------------------
module neuron_mac_sequencer
    import neuron_pkg::*;
#(
    parameter int MAX_N = 32,
    parameter int SHIFT = 0,
    parameter int ACC_W = 16 + $clog2(MAX_N + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [RAM_AW-1:0] n_inputs,
    input  logic [RAM_AW-1:0] x_base,
    input  logic [RAM_AW-1:0] w_base,
    input  logic [RAM_AW-1:0] out_addr,
`ifdef NEURON_BIAS_EN
    input  logic [RAM_AW-1:0] bias_addr,
`endif
    output logic              busy,
    output logic              done,
    output logic [RAM_DW-1:0] result,
    output logic [RAM_AW-1:0] ram_read_address,
    output logic              ram_oe,
    input  logic [RAM_DW-1:0] ram_read_data,
    output logic [RAM_AW-1:0] ram_write_address,
    output logic [RAM_DW-1:0] ram_write_data,
    output logic              ram_wre
);

    state_t state;
    state_t state_next;

    logic [RAM_AW-1:0] n_reg;
    logic [RAM_AW-1:0] x_base_reg;
    logic [RAM_AW-1:0] w_base_reg;
    logic [RAM_AW-1:0] out_addr_reg;
`ifdef NEURON_BIAS_EN
    logic [RAM_AW-1:0] bias_addr_reg;
`endif
    logic [RAM_AW-1:0] idx;
    logic [RAM_DW-1:0] x_reg;
    logic [ACC_W-1:0]  acc;
    logic [RAM_DW-1:0] result_reg;
    logic [RAM_DW-1:0] sat_value;
    logic [15:0]       product;
    logic              last_idx;

    // Operands are zero-padded so the multiply is evaluated at full 16 bits.
    assign product  = {8'd0, x_reg} * {8'd0, ram_read_data};
    assign last_idx = (idx == n_reg - 8'd1);
    assign result   = result_reg;

    neuron_act_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_act_sat (
        .acc (acc),
        .act (sat_value)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and RAM port decode. Unused address/data outputs are held
    // at zero so the RAM never sees X while its enables are low.
    always_comb begin
        state_next        = state;
        busy              = 1'b1;
        done              = 1'b0;
        ram_read_address  = '0;
        ram_oe            = 1'b0;
        ram_write_address = '0;
        ram_write_data    = '0;
        ram_wre           = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
`ifdef NEURON_BIAS_EN
                    state_next = BIAS;
`else
                    state_next = (n_inputs != 8'd0) ? RD_X : WRITE;
`endif
                end
            end
`ifdef NEURON_BIAS_EN
            BIAS: begin
                ram_read_address = bias_addr_reg;
                ram_oe           = 1'b1;
                state_next       = (n_reg != 8'd0) ? RD_X : WRITE;
            end
`endif
            RD_X: begin
                ram_read_address = x_base_reg + idx;
                ram_oe           = 1'b1;
                state_next       = RD_W;
            end
            RD_W: begin
                ram_read_address = w_base_reg + idx;
                ram_oe           = 1'b1;
                state_next       = last_idx ? WRITE : RD_X;
            end
            WRITE: begin
                ram_write_address = out_addr_reg;
                ram_write_data    = sat_value;
                ram_wre           = 1'b1;
                state_next        = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: configuration latch, operand capture and accumulation.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            n_reg         <= '0;
            x_base_reg    <= '0;
            w_base_reg    <= '0;
            out_addr_reg  <= '0;
`ifdef NEURON_BIAS_EN
            bias_addr_reg <= '0;
`endif
            idx           <= '0;
            x_reg         <= '0;
            acc           <= '0;
            result_reg    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        n_reg         <= n_inputs;
                        x_base_reg    <= x_base;
                        w_base_reg    <= w_base;
                        out_addr_reg  <= out_addr;
`ifdef NEURON_BIAS_EN
                        bias_addr_reg <= bias_addr;
`endif
                        idx           <= '0;
                        acc           <= '0;
                    end
                end
`ifdef NEURON_BIAS_EN
                BIAS: begin
                    acc <= {{(ACC_W-RAM_DW){1'b0}}, ram_read_data};
                end
`endif
                RD_X: begin
                    x_reg <= ram_read_data;
                end
                RD_W: begin
                    acc <= acc + {{(ACC_W-16){1'b0}}, product};
                    if (!last_idx) begin
                        idx <= idx + 8'd1;
                    end
                end
                WRITE: begin
                    result_reg <= sat_value;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_mac_sequencer.sv
// ---------------------------------------------------------------------------
// tb_neuron_mac_sequencer
// Self-checking bench for neuron_mac_sequencer. Instance "a" uses SHIFT=0
// and carries the main tests; instance "b" uses SHIFT=9 for the shifted
// saturation case. Each instance owns a behavioural 256x8 RAM.
// ---------------------------------------------------------------------------
module tb_neuron_mac_sequencer;

`ifdef NEURON_BIAS_EN
    localparam int BIAS_EXTRA = 1;
`else
    localparam int BIAS_EXTRA = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic [7:0] n_inputs, x_base, w_base, out_addr;
`ifdef NEURON_BIAS_EN
    logic [7:0] bias_addr;
`endif
    logic       busy, done;
    logic [7:0] result;
    logic [7:0] ram_read_address, ram_read_data, ram_write_address, ram_write_data;
    logic       ram_oe, ram_wre;

    logic       start_b;
    logic [7:0] n_b, x_b, w_b, o_b;
`ifdef NEURON_BIAS_EN
    logic [7:0] bias_b;
`endif
    logic       busy_b, done_b;
    logic [7:0] result_b;
    logic [7:0] ra_b, rd_b, wa_b, wd_b;
    logic       oe_b, wre_b;

    neuron_mac_sequencer #(.MAX_N(32), .SHIFT(0)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .n_inputs          (n_inputs),
        .x_base            (x_base),
        .w_base            (w_base),
        .out_addr          (out_addr),
`ifdef NEURON_BIAS_EN
        .bias_addr         (bias_addr),
`endif
        .busy              (busy),
        .done              (done),
        .result            (result),
        .ram_read_address  (ram_read_address),
        .ram_oe            (ram_oe),
        .ram_read_data     (ram_read_data),
        .ram_write_address (ram_write_address),
        .ram_write_data    (ram_write_data),
        .ram_wre           (ram_wre)
    );

    neuron_mac_sequencer #(.MAX_N(32), .SHIFT(9)) dut_b (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start_b),
        .n_inputs          (n_b),
        .x_base            (x_b),
        .w_base            (w_b),
        .out_addr          (o_b),
`ifdef NEURON_BIAS_EN
        .bias_addr         (bias_b),
`endif
        .busy              (busy_b),
        .done              (done_b),
        .result            (result_b),
        .ram_read_address  (ra_b),
        .ram_oe            (oe_b),
        .ram_read_data     (rd_b),
        .ram_write_address (wa_b),
        .ram_write_data    (wd_b),
        .ram_wre           (wre_b)
    );

    // Behavioural RAMs: combinational read, write on the rising edge. The
    // bench loads contents through a poke port so each array has one writer.
    logic [7:0] mem   [0:255];
    logic [7:0] mem_b [0:255];
    logic       pl_we, pl_we_b;
    logic [7:0] pl_addr, pl_data;

    assign ram_read_data = ram_oe ? mem[ram_read_address] : 8'h00;
    assign rd_b          = oe_b ? mem_b[ra_b] : 8'h00;

    always @(posedge clk) begin
        if (ram_wre) mem[ram_write_address] <= ram_write_data;
        else if (pl_we) mem[pl_addr] <= pl_data;
        if (wre_b) mem_b[wa_b] <= wd_b;
        else if (pl_we_b) mem_b[pl_addr] <= pl_data;
    end

    // Bus monitor for instance a: count writes and log every read address.
    int         wre_count = 0;
    logic [7:0] rd_log[$];
    always @(posedge clk) begin
        if (ram_wre) wre_count <= wre_count + 1;
        if (ram_oe) rd_log.push_back(ram_read_address);
    end

    int n_compared = 0;
    int n_failed   = 0;

    typedef struct {
        string name;
        int    n;
        int    xb;
        int    wb;
        int    oa;
        int    exp_res;
        int    exp_lat;
    } vec_t;

    vec_t vecs[7];

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_compared++;
        if (actual !== expected) begin
            n_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic poke(input logic [7:0] a, input logic [7:0] d, input logic to_b);
        @(negedge clk);
        pl_addr = a;
        pl_data = d;
        pl_we   = ~to_b;
        pl_we_b = to_b;
        @(posedge clk);
        #1;
        pl_we   = 1'b0;
        pl_we_b = 1'b0;
    endtask

    // Reference: dot product over current RAM contents, optional bias,
    // then shift and clamp to 255.
    function automatic int model(input int n, input int xb, input int wb, input int bb, input int sh);
        longint acc;
        acc = 0;
`ifdef NEURON_BIAS_EN
        acc = mem[bb % 256];
`else
        if (bb < 0) acc = 0;
`endif
        for (int i = 0; i < n; i++)
            acc += longint'(mem[(xb + i) % 256]) * longint'(mem[(wb + i) % 256]);
        acc = acc >>> sh;
        return (acc > 255) ? 255 : int'(acc);
    endfunction

    // Run one evaluation on instance a; report the cycle (relative to the
    // start edge) of the write and of done, plus the written data.
    task automatic applyStimulus(input int n, input int xb, input int wb, input int oa, input int ba,
                                 output int latency, output int write_cyc, output int wdata);
        @(negedge clk);
        n_inputs = n[7:0];
        x_base   = xb[7:0];
        w_base   = wb[7:0];
        out_addr = oa[7:0];
`ifdef NEURON_BIAS_EN
        bias_addr = ba[7:0];
`else
        if (ba < 0) out_addr = oa[7:0];
`endif
        start = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        latency   = -1;
        write_cyc = -1;
        wdata     = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (ram_wre) begin
                write_cyc = c;
                wdata     = int'(ram_write_data);
            end
            if (done) begin
                latency = c;
                break;
            end
        end
    endtask

    // Run a vector and check write timing, data, result, RAM and busy fall.
    task automatic runCheck(input string name, input int n, input int xb, input int wb, input int oa,
                            input int ba, input int exp_res, input int exp_lat);
        int lat, wc, wd;
        applyStimulus(n, xb, wb, oa, ba, lat, wc, wd);
        checkOutput({name, " done latency"}, lat, exp_lat);
        checkOutput({name, " write cycle"}, wc, exp_lat - 1);
        checkOutput({name, " write data"}, wd, exp_res);
        checkOutput({name, " result"}, int'(result), exp_res);
        checkOutput({name, " mem[out]"}, int'(mem[oa % 256]), exp_res);
        @(negedge clk);
        checkOutput({name, " busy after done"}, int'(busy), 0);
        checkOutput({name, " done one cycle"}, int'(done), 0);
    endtask

    initial begin
        int lat, wc, wd, exp_v, extra_done, base_w, rn, rx, rw, ro, rb;
        start = 0; start_b = 0; pl_we = 0; pl_we_b = 0; pl_addr = 0; pl_data = 0;
        n_inputs = 0; x_base = 0; w_base = 0; out_addr = 0;
        n_b = 8'd2; x_b = 8'd30; w_b = 8'd32; o_b = 8'd50;
`ifdef NEURON_BIAS_EN
        bias_addr = 8'd100; bias_b = 8'd100;
`endif
        rst_n = 1'b0;

        vecs[0] = '{"basic",   4, 0, 4, 20, 114, 10};
        vecs[1] = '{"n2",      2, 0, 4, 21, 95,  6};
        vecs[2] = '{"n1",      1, 2, 6, 22, 15,  4};
        vecs[3] = '{"zero_n",  0, 0, 4, 23, 0,   2};
        vecs[4] = '{"squares", 4, 0, 0, 24, 250, 10};
        vecs[5] = '{"w_sq",    3, 4, 4, 25, 50,  8};
        vecs[6] = '{"offset",  3, 1, 5, 26, 74,  8};

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset result", int'(result), 0);
        checkOutput("reset oe", int'(ram_oe), 0);
        checkOutput("reset wre", int'(ram_wre), 0);
        checkOutput("reset raddr", int'(ram_read_address), 0);
        rst_n = 1'b1;

        for (int a = 0; a < 256; a++) poke(a[7:0], 8'd0, 1'b0);
        poke(8'd100, 8'd0, 1'b1);
        poke(8'd0, 8'd10, 1'b0); poke(8'd1, 8'd11, 1'b0);
        poke(8'd2, 8'd5, 1'b0);  poke(8'd3, 8'd2, 1'b0);
        poke(8'd4, 8'd4, 1'b0);  poke(8'd5, 8'd5, 1'b0);
        poke(8'd6, 8'd3, 1'b0);  poke(8'd7, 8'd2, 1'b0);
        poke(8'd23, 8'd99, 1'b0);

        for (int i = 0; i < 7; i++)
            runCheck(vecs[i].name, vecs[i].n, vecs[i].xb, vecs[i].wb, vecs[i].oa, 100,
                     vecs[i].exp_res, vecs[i].exp_lat + BIAS_EXTRA);

`ifdef NEURON_BIAS_EN
        poke(8'd100, 8'd7, 1'b0);
        runCheck("bias_zero_n", 0, 0, 4, 29, 100, 7, 3);
        poke(8'd100, 8'd0, 1'b0);
`endif

        // Saturation: SHIFT=0 clamps 130050 to 255; SHIFT=9 gives 254.
        for (int a = 30; a < 34; a++) begin
            poke(a[7:0], 8'd255, 1'b0);
            poke(a[7:0], 8'd255, 1'b1);
        end
        runCheck("sat_shift0", 2, 30, 32, 27, 100, 255, 6 + BIAS_EXTRA);
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1;
        start_b = 1'b0;
        lat = -1;
        for (int c = 1; c <= 50; c++) begin
            @(negedge clk);
            if (done_b) begin
                lat = c;
                break;
            end
        end
        checkOutput("sat_shift9 latency", lat, 6 + BIAS_EXTRA);
        checkOutput("sat_shift9 result", int'(result_b), 254);
        checkOutput("sat_shift9 mem[out]", int'(mem_b[50]), 254);
        @(negedge clk);
        checkOutput("sat_shift9 busy after", int'(busy_b), 0);

        // Address wrap plus a start pulse while busy that must be dropped.
        poke(8'd254, 8'd1, 1'b0); poke(8'd255, 8'd2, 1'b0);
        poke(8'd40, 8'd1, 1'b0);  poke(8'd41, 8'd2, 1'b0);
        poke(8'd42, 8'd3, 1'b0);  poke(8'd43, 8'd4, 1'b0);
        base_w = rd_log.size();
        fork
            applyStimulus(4, 254, 40, 30, 100, lat, wc, wd);
            begin
                repeat (4) @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join
        checkOutput("wrap latency", lat, 10 + BIAS_EXTRA);
        checkOutput("wrap result", int'(result), 79);
        extra_done = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done || busy) extra_done++;
        end
        checkOutput("ignored start no rerun", extra_done, 0);
        checkOutput("wrap read count", rd_log.size() - base_w, 8 + BIAS_EXTRA);
        begin
            int exp_addr[8] = '{254, 40, 255, 41, 0, 42, 1, 43};
            for (int i = 0; i < 8; i++)
                if (base_w + BIAS_EXTRA + i < rd_log.size())
                    checkOutput($sformatf("wrap read addr %0d", i),
                                int'(rd_log[base_w + BIAS_EXTRA + i]), exp_addr[i]);
        end

        // Reset during RD_W of idx 2 aborts without a write.
        poke(8'd28, 8'd77, 1'b0);
        base_w = wre_count;
        @(negedge clk);
        n_inputs = 8'd4; x_base = 8'd0; w_base = 8'd4; out_addr = 8'd28;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (6 + BIAS_EXTRA) @(negedge clk);
        checkOutput("abort point raddr", int'(ram_read_address), 6);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abort busy", int'(busy), 0);
        checkOutput("abort done", int'(done), 0);
        checkOutput("abort result", int'(result), 0);
        checkOutput("abort oe", int'(ram_oe), 0);
        checkOutput("abort wre", int'(ram_wre), 0);
        checkOutput("abort raddr", int'(ram_read_address), 0);
        checkOutput("abort waddr", int'(ram_write_address), 0);
        checkOutput("abort wdata", int'(ram_write_data), 0);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        checkOutput("abort no write", wre_count - base_w, 0);
        checkOutput("abort mem kept", int'(mem[28]), 77);
        runCheck("after_abort", 4, 0, 4, 28, 100, 114, 10 + BIAS_EXTRA);

        // Randomized evaluations against the reference model.
        for (int a = 0; a < 256; a++) poke(a[7:0], 8'($urandom_range(0, 255)), 1'b0);
        for (int t = 0; t < 20; t++) begin
            rn = $urandom_range(0, 32);
            rx = $urandom_range(0, 255);
            rw = $urandom_range(0, 255);
            ro = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            exp_v = model(rn, rx, rw, rb, 0);
            runCheck($sformatf("rand%0d", t), rn, rx, rw, ro, rb, exp_v, 2 * rn + 2 + BIAS_EXTRA);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
        $finish;
    end

endmodule

// File: doc/neuron_mac_sequencer.md
# neuron_mac_sequencer

Sequences one neuron evaluation over the neuron dual-port RAM. On `start`, it reads N input activations and N weights through the RAM's single read port and accumulates their products. It then writes one shifted, saturated 8-bit result back through the write port and pulses `done`. It is the only master of the RAM's `read_address`/`oe`/`write_address`/`write_data`/`wre` inputs.

## Interface
- `MAX_N`, 32: largest supported input count. Sets accumulator width.
- `SHIFT`, 0: fixed right shift applied to the accumulator before saturation.
- `ACC_W`, 16+clog2(`MAX_N`+1): accumulator width.

Ports:
- `clk`, in, 1: sole clock, rising edge.
- `rst_n`, in, 1: synchronous, active-low reset.
- `start`, in, 1: request one evaluation. Sampled only in IDLE.
- `n_inputs`, in, 8: N. Latched at start.
- `x_base`, in, 8: RAM address of x[0]. Latched at start.
- `w_base`, in, 8: RAM address of w[0]. Latched at start.
- `out_addr`, in, 8: RAM address for the result. Latched at start.
- `bias_addr`, in, 8: RAM address of the bias. Latched at start. Present only with `NEURON_BIAS_EN`.
- `busy`, out, 1: high in every state except IDLE.
- `done`, out, 1: one-cycle pulse after the result write.
- `result`, out, 8: last written result. Held until the next WRITE.
- `ram_read_address`, out, 8: to RAM `read_address`.
- `ram_oe`, out, 1: to RAM `oe`.
- `ram_read_data`, in, 8: from RAM `read_data`. Combinational, valid in the same cycle.
- `ram_write_address`, out, 8: to RAM `write_address`.
- `ram_write_data`, out, 8: to RAM `write_data`.
- `ram_wre`, out, 1: to RAM `wre`.

## Operation
- States: IDLE, BIAS (macro only), RD_X, RD_W, WRITE, DONE.
- IDLE
  - `busy`=0, `ram_oe`=0, `ram_wre`=0.
  - If `start`=1: latch configuration, set idx=0, acc=0.
  - Next state: BIAS if enabled; else RD_X if N>0; else WRITE.
- BIAS
  - Drive `ram_read_address`=bias_addr and `ram_oe`=1.
  - acc ← zero-extended `ram_read_data`.
  - Next state: RD_X if N>0, else WRITE.
- RD_X
  - Drive `ram_read_address`=x_base+idx and `ram_oe`=1.
  - x_reg ← `ram_read_data`.
  - Next state: RD_W.
- RD_W
  - Drive `ram_read_address`=w_base+idx and `ram_oe`=1.
  - acc ← acc + x_reg×`ram_read_data`, as an unsigned 8×8→16 product zero-extended to ACC_W.
  - If idx==N-1: next state WRITE. Otherwise idx++ and next state RD_X.
- WRITE
  - Drive `ram_write_address`=out_addr, `ram_write_data`=sat(acc>>SHIFT), `ram_wre`=1.
  - `result` ← the same value.
  - sat(v) = v if v≤255, else 255.
  - Next state: DONE.
- DONE
  - `done`=1 for this cycle only.
  - Next state: IDLE.
- Address arithmetic is 8-bit modulo 256. base+idx wraps silently.
- When `ram_oe`=0 or `ram_wre`=0, the corresponding address and data outputs are driven to 0. They are never left as X or Z.
- N > `MAX_N` is not guarded. Accumulator overflow is undefined in that case.
- `start` while `busy`=1 is ignored and not queued.
- Configuration inputs may change freely while busy. Only the values latched in IDLE are used.

## Timing
- Start is sampled at edge k. From there:
  - First RAM read occurs in cycle k+1.
  - WRITE cycle is k+2N+1 (k+2N+2 with bias).
  - `done` is high in the following cycle.
  - `busy` falls one cycle after `done`.
- The RAM commits the write at the rising edge that ends the WRITE cycle.
- Back-to-back operation: a start asserted during DONE is ignored. The earliest accepted start is the first IDLE cycle. The minimum period is 2N+3 cycles (2N+4 with bias).
- Reset (`rst_n`=0 at an edge):
  - Go to IDLE.
  - `busy`=0, `done`=0, `result`=0, `ram_oe`=0, `ram_wre`=0, all addresses and write data 0.
  - acc, idx and x_reg are cleared.
  - Reset mid-operation aborts the operation. No write is issued. A WRITE already committed at an earlier edge stays in RAM.
- Accumulation never reads the RAM location being written, because no write occurs outside WRITE. RAM write-forwarding is therefore never exercised by this block.

## Configuration
- `NEURON_BIAS_EN` defined:
  - BIAS state and `bias_addr` port exist.
  - The accumulator is preloaded with mem[bias_addr] before the first product.
- `NEURON_BIAS_EN` undefined:
  - No port and no state.
  - The accumulator starts at 0.

## Structure
- Shared package `neuron_pkg` holds:
  - The state enum.
  - `RAM_AW`=8 and `RAM_DW`=8.
  - The saturation max constant 255.
- Sub-module `neuron_act_sat`: shifts by SHIFT and saturates ACC_W bits to 8. Purely combinational, reused by later layer blocks.
- The RAM is instantiated by the parent, not inside this block.

## Test plan
- Basic evaluation:
  - RAM 0..3 = 10,11,5,2; RAM 4..7 = 4,5,3,2; x_base=0, w_base=4, N=4, out_addr=20, SHIFT=0.
  - mem[20]=114 and `result`=114.
  - `done` pulses exactly 10 cycles after the start edge.
- Saturation and shift:
  - N=2, all operands 255.
  - With SHIFT=0: writes 255.
  - With SHIFT=9: acc 130050>>9 = 254, so writes 254.
- Zero inputs:
  - N=0.
  - WRITE in cycle k+1, writes 0 to out_addr, `done` at k+2.
  - With `NEURON_BIAS_EN` and mem[bias_addr]=7: writes 7.
- Wrap and ignore:
  - x_base=254, N=4: reads addresses 254, 255, 0, 1.
  - `start` pulsed mid-run: no second run, `done` pulses once.
- Reset mid-run:
  - `rst_n`=0 during RD_W of idx 2.
  - No `ram_wre` is ever asserted, mem[out_addr] is unchanged.
  - All outputs are 0 the cycle after the reset edge.
  - A new start afterwards completes correctly.
